// File: rtl/enigma_plugboard.sv
// Enigma plugboard: involutive 26-letter swap table with a one-deep output register.
// Optional macro PLUGBOARD_CONFLICT_CHECK_EN rejects pair writes on already-paired letters.
module enigma_plugboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_char,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_clear,
    input  logic [4:0] cfg_a,
    input  logic [4:0] cfg_b,
    output logic       cfg_err,
    output logic [3:0] pair_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_map [26];
    logic [4:0] r_cnt;
    logic       r_out_valid;
    logic [4:0] r_out_char;
    logic       r_cfg_err;
    logic [3:0] r_pair_count;

    logic       w_in_fire;
    logic [4:0] w_lut;
    logic       w_cmd;
    logic       w_clr_go;
    logic       w_pair_cmd;
    logic [4:0] w_map_a;
    logic [4:0] w_map_b;
    logic       w_a_free;
    logic       w_b_free;
    logic       w_exist;
    logic       w_bad;
    logic       w_conflict;
    logic       w_rej;
    logic       w_wr;
    logic [3:0] w_broken;
    logic       w_clr_last;

    assign cfg_ready  = (r_state == IDLE);
    assign in_ready   = cfg_ready && (!r_out_valid || out_ready);
    assign out_valid  = r_out_valid;
    assign out_char   = r_out_char;
    assign cfg_err    = r_cfg_err;
    assign pair_count = r_pair_count;

    assign w_in_fire  = in_valid && in_ready;
    assign w_lut      = (in_char < 5'd26) ? r_map[in_char] : in_char;

    assign w_cmd      = cfg_valid && cfg_ready;
    assign w_clr_go   = w_cmd && cfg_clear;
    assign w_pair_cmd = w_cmd && !cfg_clear;

    assign w_map_a    = (cfg_a < 5'd26) ? r_map[cfg_a] : cfg_a;
    assign w_map_b    = (cfg_b < 5'd26) ? r_map[cfg_b] : cfg_b;
    assign w_a_free   = (w_map_a == cfg_a);
    assign w_b_free   = (w_map_b == cfg_b);
    assign w_exist    = (w_map_a == cfg_b);
    assign w_bad      = (cfg_a == cfg_b) || (cfg_a > 5'd25)
                     || (cfg_b > 5'd25);

`ifdef PLUGBOARD_CONFLICT_CHECK_EN
    assign w_conflict = !w_exist && (!w_a_free || !w_b_free);
`else
    assign w_conflict = 1'b0;
`endif

    assign w_rej      = w_pair_cmd && (w_bad || w_conflict);
    assign w_wr       = w_pair_cmd && !w_bad && !w_conflict && !w_exist;
    assign w_broken   = {3'd0, !w_a_free} + {3'd0, !w_b_free};
    assign w_clr_last = (r_cnt == 5'd25);

    // Next-state logic: clear command enters CLEAR, last index returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (w_clr_go) w_state_nxt = CLEAR;
            CLEAR: if (w_clr_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Output register: lookup uses the table as it was before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_char  <= 5'd31;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_char  <= w_lut;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Table, clear sweep, pair count and error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 26; i++) r_map[i] <= 5'(i);
            r_cnt        <= 5'd0;
            r_cfg_err    <= 1'b0;
            r_pair_count <= 4'd0;
        end else begin
            r_cfg_err <= 1'b0;
            if (r_state == CLEAR) begin
                r_map[r_cnt] <= r_cnt;
                if (w_clr_last) begin
                    r_cnt        <= 5'd0;
                    r_pair_count <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 5'd1;
                end
            end else if (w_rej) begin
                r_cfg_err <= 1'b1;
            end else if (w_wr) begin
                // Old partners go back to identity; new pair written last.
                if (!w_a_free) r_map[w_map_a] <= w_map_a;
                if (!w_b_free) r_map[w_map_b] <= w_map_b;
                r_map[cfg_a] <= cfg_b;
                r_map[cfg_b] <= cfg_a;
                r_pair_count <= r_pair_count + 4'd1 - w_broken;
            end
        end
    end

endmodule

// File: tb/tb_enigma_plugboard.sv
// Directed self-checking bench for enigma_plugboard.
// Each task drives one scenario and checks results inline.
module tb_enigma_plugboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_char;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_clear;
    logic [4:0] cfg_a;
    logic [4:0] cfg_b;
    logic       cfg_err;
    logic [3:0] pair_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    enigma_plugboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_clear (cfg_clear),
        .cfg_a     (cfg_a),
        .cfg_b     (cfg_b),
        .cfg_err   (cfg_err),
        .pair_count(pair_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_char   = 5'd0;
        out_ready = 1'b1;
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        cfg_a     = 5'd0;
        cfg_b     = 5'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Send one char and return what the output register captured.
    task automatic xlate(input logic [4:0] c, output logic [4:0] o,
                         output logic ok);
        int n = 0;
        out_ready = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok       = in_ready;
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
        o  = out_char;
        ok = ok && out_valid;
        tick();
    endtask

    // Issue one pair write; err reports the pulse seen after the edge.
    task automatic pair(input logic [4:0] a, input logic [4:0] b,
                        output logic err);
        int n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        cfg_valid = 1'b1;
        cfg_clear = 1'b0;
        cfg_a     = a;
        cfg_b     = b;
        tick();
        cfg_valid = 1'b0;
        err = cfg_err;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_valid !== 1'b0 || out_char !== 5'd31 || cfg_err !== 1'b0
            || pair_count !== 4'd0 || cfg_ready !== 1'b1
            || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: ov=%b oc=%0d err=%b pc=%0d cr=%b ir=%b want 0 31 0 0 1 1",
                     out_valid, out_char, cfg_err, pair_count,
                     cfg_ready, in_ready);
        end
    endtask

    task automatic test_stream();
        logic [4:0] v [6];
        v[0] = 5'd0; v[1] = 5'd4; v[2] = 5'd25;
        v[3] = 5'd31; v[4] = 5'd26; v[5] = 5'd30;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_char  = v[i];
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_char !== v[i]) begin
                n_fail++;
                $display("FAIL stream[%0d]: ov=%b oc=%0d want 1 %0d",
                         i, out_valid, out_char, v[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_pair();
        logic [4:0] o;
        logic ok, err;
        logic [4:0] q [3];
        logic [4:0] e [3];
        pair(5'd0, 5'd1, err);
        n_tests++;
        if (err !== 1'b0 || pair_count !== 4'd1) begin
            n_fail++;
            $display("FAIL pair01: err=%b pc=%0d want 0 1", err, pair_count);
        end
        q[0] = 5'd0; q[1] = 5'd1; q[2] = 5'd2;
        e[0] = 5'd1; e[1] = 5'd0; e[2] = 5'd2;
        for (int i = 0; i < 3; i++) begin
            xlate(q[i], o, ok);
            n_tests++;
            if (!ok || o !== e[i]) begin
                n_fail++;
                $display("FAIL pair_map[%0d]: got %0d ok=%b want %0d",
                         q[i], o, ok, e[i]);
            end
        end
        pair(5'd1, 5'd0, err);
        n_tests++;
        if (err !== 1'b0 || pair_count !== 4'd1) begin
            n_fail++;
            $display("FAIL pair_exist: err=%b pc=%0d want 0 1", err, pair_count);
        end
    endtask

    task automatic test_reject();
        logic [4:0] o;
        logic ok, err;
        pair(5'd3, 5'd3, err);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL rej_same: err=%b want 1", err);
        end
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_pulse: err=%b want 0", cfg_err);
        end
        pair(5'd3, 5'd27, err);
        n_tests++;
        if (err !== 1'b1 || pair_count !== 4'd1) begin
            n_fail++;
            $display("FAIL rej_range: err=%b pc=%0d want 1 1", err, pair_count);
        end
        xlate(5'd3, o, ok);
        n_tests++;
        if (!ok || o !== 5'd3) begin
            n_fail++;
            $display("FAIL rej_map: got %0d want 3", o);
        end
    endtask

    task automatic test_overlap();
        logic [4:0] o;
        logic ok, err;
        logic [4:0] e [3];
        logic       e_err;
        do_reset();
        pair(5'd0, 5'd1, err);
        pair(5'd1, 5'd2, err);
`ifdef PLUGBOARD_CONFLICT_CHECK_EN
        e_err = 1'b1;
        e[0] = 5'd1; e[1] = 5'd0; e[2] = 5'd2;
`else
        e_err = 1'b0;
        e[0] = 5'd0; e[1] = 5'd2; e[2] = 5'd1;
`endif
        n_tests++;
        if (err !== e_err || pair_count !== 4'd1) begin
            n_fail++;
            $display("FAIL overlap: err=%b pc=%0d want %b 1",
                     err, pair_count, e_err);
        end
        for (int i = 0; i < 3; i++) begin
            xlate(5'(i), o, ok);
            n_tests++;
            if (!ok || o !== e[i]) begin
                n_fail++;
                $display("FAIL overlap_map[%0d]: got %0d want %0d", i, o, e[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [4:0] o;
        logic ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_char   = 5'd7;
        cfg_valid = 1'b1;
        cfg_clear = 1'b0;
        cfg_a     = 5'd7;
        cfg_b     = 5'd8;
        tick();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        n_tests++;
        if (out_char !== 5'd7) begin
            n_fail++;
            $display("FAIL same_cycle: got %0d want 7", out_char);
        end
        tick();
        xlate(5'd7, o, ok);
        n_tests++;
        if (!ok || o !== 5'd8) begin
            n_fail++;
            $display("FAIL same_cycle_after: got %0d want 8", o);
        end
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = 5'd5;
        tick();
        in_char = 5'd6;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || out_char !== 5'd5) begin
                n_fail++;
                $display("FAIL stall[%0d]: ir=%b ov=%b oc=%0d want 0 1 5",
                         i, in_ready, out_valid, out_char);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: ir=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_char !== 5'd6) begin
            n_fail++;
            $display("FAIL stall_next: ov=%b oc=%0d want 1 6", out_valid, out_char);
        end
        tick();
    endtask

    task automatic test_clear();
        logic [4:0] o;
        logic ok, err;
        int n;
        do_reset();
        for (int i = 0; i < 13; i++) pair(5'(2 * i), 5'(2 * i + 1), err);
        n_tests++;
        if (pair_count !== 4'd13) begin
            n_fail++;
            $display("FAIL clr_count13: got %0d want 13", pair_count);
        end
        xlate(5'd25, o, ok);
        n_tests++;
        if (!ok || o !== 5'd24) begin
            n_fail++;
            $display("FAIL clr_pre_map: got %0d want 24", o);
        end
        cfg_valid = 1'b1;
        cfg_clear = 1'b1;
        cfg_a     = 5'd2;
        cfg_b     = 5'd9;
        tick();
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_in_ready: got %b want 0", in_ready);
        end
        n = 0;
        while (!cfg_ready && n < 60) begin
            n++;
            tick();
        end
        n_tests++;
        if (n != 26) begin
            n_fail++;
            $display("FAIL clr_busy: got %0d cycles want 26", n);
        end
        n_tests++;
        if (pair_count !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_count: got %0d want 0", pair_count);
        end
        for (int i = 0; i < 26; i += 5) begin
            xlate(5'(i), o, ok);
            n_tests++;
            if (!ok || o !== 5'(i)) begin
                n_fail++;
                $display("FAIL clr_map[%0d]: got %0d want %0d", i, o, i);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic err;
        pair(5'd4, 5'd5, err);
        cfg_valid = 1'b1;
        cfg_clear = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if (cfg_ready !== 1'b1 || pair_count !== 4'd0
            || out_valid !== 1'b0 || out_char !== 5'd31) begin
            n_fail++;
            $display("FAIL reset_abort: cr=%b pc=%0d ov=%b oc=%0d want 1 0 0 31",
                     cfg_ready, pair_count, out_valid, out_char);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_pair();
        test_reject();
        test_same_cycle();
        test_overlap();
        test_back_to_back_stall();
        test_clear();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
